// File: rtl/link_word_aligner_if.sv
// Word-aligner bus: unaligned deserializer words in, aligned words and lock status out.
// master drives the raw stream and control inputs; slave is the aligner itself.
interface link_word_aligner_if;
  logic [31:0] raw_word;
  logic [31:0] align_pattern;
  logic        link_reset_request;
  logic [31:0] data_out;
  logic        link_aligned;
  logic [4:0]  offset_out;
  logic [7:0]  link_aligned_count;
  logic [7:0]  link_error_count;

  modport master (
    output raw_word, align_pattern, link_reset_request,
    input  data_out, link_aligned, offset_out, link_aligned_count, link_error_count
  );

  modport slave (
    input  raw_word, align_pattern, link_reset_request,
    output data_out, link_aligned, offset_out, link_aligned_count, link_error_count
  );
endinterface

// File: rtl/link_word_aligner.sv
// Searches all 32 bit offsets of a free-running word stream for the idle pattern,
// locks after LOCK_COUNT confirmations and delivers aligned words; re-searches on slips.
module link_word_aligner #(
  parameter int LOCK_COUNT = 8,
  parameter int ERR_LIMIT  = 4
) (
  input  logic               clk40,
  input  logic               rstb,
  link_word_aligner_if.slave bus
);

  typedef enum logic [1:0] {SEARCH, CONFIRM, ALIGNED} state_t;

  localparam logic [7:0] LOCK_C = 8'(LOCK_COUNT);
  localparam logic [7:0] ERR_C  = 8'(ERR_LIMIT);

  state_t      state_q, state_d;
  logic [31:0] prev_word_q, prev_word_d;
  logic [31:0] data_out_q, data_out_d;
  logic [4:0]  offset_q, offset_d;
  logic [7:0]  match_cnt_q, match_cnt_d;
  logic [7:0]  err_run_q, err_run_d;
  logic [7:0]  aligned_cnt_q, aligned_cnt_d;
  logic [7:0]  err_cnt_q, err_cnt_d;
  logic        link_aligned_q, link_aligned_d;

  logic [63:0] window;
  logic [31:0] cand [32];
  logic [31:0] match;
  logic        any_match;
  logic [4:0]  first_k;
  logic [7:0]  cnt_inc;
  logic [7:0]  run_inc;

  function automatic logic [7:0] sat_inc(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

  // Candidate k starts k bits into the window, so k = 0 is the previous word.
  assign window = {prev_word_q, bus.raw_word};

  always_comb begin
    for (int k = 0; k < 32; k++) begin
      cand[k]  = window[63-k -: 32];
      match[k] = (cand[k] == bus.align_pattern);
    end
  end

  assign any_match = |match;
  assign cnt_inc   = match_cnt_q + 8'd1;
  assign run_inc   = err_run_q + 8'd1;

  always_comb begin
    first_k = '0;
    for (int k = 31; k >= 0; k--) begin
      if (match[k]) first_k = 5'(k);
    end
  end

  always_comb begin
    state_d       = state_q;
    prev_word_d   = bus.raw_word;
    data_out_d    = cand[offset_q];
    offset_d      = offset_q;
    match_cnt_d   = match_cnt_q;
    err_run_d     = err_run_q;
    aligned_cnt_d = aligned_cnt_q;
    err_cnt_d     = err_cnt_q;

    case (state_q)
      SEARCH: begin
        if (any_match) begin
          offset_d    = first_k;
          match_cnt_d = 8'd1;
          state_d     = CONFIRM;
        end
      end
      CONFIRM: begin
        if (match[offset_q]) begin
          match_cnt_d = cnt_inc;
          if (cnt_inc == LOCK_C) begin
            state_d       = ALIGNED;
            aligned_cnt_d = sat_inc(aligned_cnt_q);
          end
        end else begin
          state_d     = SEARCH;
          match_cnt_d = 8'd0;
        end
      end
      ALIGNED: begin
        // Payload words match nowhere; only a match at a different offset is a slip.
        if (match[offset_q] || !any_match) begin
          err_run_d = 8'd0;
        end else begin
          err_cnt_d = sat_inc(err_cnt_q);
          if (run_inc == ERR_C) begin
            state_d     = SEARCH;
            err_run_d   = 8'd0;
            match_cnt_d = 8'd0;
          end else begin
            err_run_d = run_inc;
          end
        end
      end
      default: state_d = SEARCH;
    endcase

    if (bus.link_reset_request) begin
      state_d       = SEARCH;
      offset_d      = offset_q;
      match_cnt_d   = 8'd0;
      err_run_d     = 8'd0;
      err_cnt_d     = 8'd0;
      aligned_cnt_d = aligned_cnt_q;
    end

    link_aligned_d = (state_d == ALIGNED);
  end

  always_ff @(posedge clk40 or negedge rstb) begin
    if (!rstb) begin
      state_q        <= SEARCH;
      prev_word_q    <= '0;
      data_out_q     <= '0;
      offset_q       <= '0;
      match_cnt_q    <= '0;
      err_run_q      <= '0;
      aligned_cnt_q  <= '0;
      err_cnt_q      <= '0;
      link_aligned_q <= 1'b0;
    end else begin
      state_q        <= state_d;
      prev_word_q    <= prev_word_d;
      data_out_q     <= data_out_d;
      offset_q       <= offset_d;
      match_cnt_q    <= match_cnt_d;
      err_run_q      <= err_run_d;
      aligned_cnt_q  <= aligned_cnt_d;
      err_cnt_q      <= err_cnt_d;
      link_aligned_q <= link_aligned_d;
    end
  end

  assign bus.data_out           = data_out_q;
  assign bus.link_aligned       = link_aligned_q;
  assign bus.offset_out         = offset_q;
  assign bus.link_aligned_count = aligned_cnt_q;
  assign bus.link_error_count   = err_cnt_q;

endmodule

// File: tb/tb_link_word_aligner.sv
// Bench for link_word_aligner: lock, payload, slip, reset request, saturation, async reset.
// Instance A uses default limits; instance B (ERR_LIMIT = 255) shares the same stream.
module tb_link_word_aligner;

  localparam logic [31:0] IDLE = 32'haccccccc;
  localparam logic [31:0] BAD  = 32'hacc4cccc;
  localparam logic [31:0] ZERO = 32'h00000000;

  logic clk40;
  logic rstb_a, rstb_b;
  logic [31:0] raw_drv, pat_drv;
  logic        req_drv;
  logic [31:0] a_prev;

  int n_vec;
  int n_err;

  link_word_aligner_if bus_a ();
  link_word_aligner_if bus_b ();

  assign bus_a.raw_word           = raw_drv;
  assign bus_a.align_pattern      = pat_drv;
  assign bus_a.link_reset_request = req_drv;
  assign bus_b.raw_word           = raw_drv;
  assign bus_b.align_pattern      = pat_drv;
  assign bus_b.link_reset_request = req_drv;

  link_word_aligner #(.LOCK_COUNT(8), .ERR_LIMIT(4)) dut_a (
    .clk40 (clk40),
    .rstb  (rstb_a),
    .bus   (bus_a)
  );

  link_word_aligner #(.LOCK_COUNT(8), .ERR_LIMIT(255)) dut_b (
    .clk40 (clk40),
    .rstb  (rstb_b),
    .bus   (bus_b)
  );

  initial clk40 = 1'b0;
  always #5 clk40 = ~clk40;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, actual timeout required completion");
    $fatal(1, "watchdog expired");
  end

  typedef struct {
    logic [31:0] word;
    int          k;
    int          req;
    int          al;
    int          off;
    int          ac;
    int          ec;
    int          cd;
    logic [31:0] d;
  } vec_t;

  vec_t        tbl [$];
  logic [31:0] sb  [$];

  function automatic vec_t mk(input logic [31:0] w, input int k, input int req, input int al,
                              input int off, input int ac, input int ec, input int cd,
                              input logic [31:0] d);
    vec_t v;
    v.word = w; v.k = k; v.req = req; v.al = al; v.off = off;
    v.ac = ac; v.ec = ec; v.cd = cd; v.d = d;
    return v;
  endfunction

  // Aligned word stream placed at bit offset k: raw(t) = {A(t-1), A(t)} >> k.
  function automatic logic [31:0] stream_word(input logic [31:0] prev, input logic [31:0] cur,
                                              input int k);
    logic [63:0] w;
    w = {prev, cur} >> k;
    return w[31:0];
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: actual %0h required %0h", name, act, exp);
    end
  endtask

  task automatic drive(input logic [31:0] w, input int k, input logic req);
    raw_drv = stream_word(a_prev, w, k);
    a_prev  = w;
    req_drv = req;
    @(posedge clk40);
    #1;
  endtask

  task automatic check_zero(input string tag, input logic [31:0] d, input logic al,
                            input logic [4:0] off, input logic [7:0] ac, input logic [7:0] ec);
    check({tag, "_data"},   d,        32'h0);
    check({tag, "_aligned"}, 32'(al),  32'h0);
    check({tag, "_offset"},  32'(off), 32'h0);
    check({tag, "_acount"},  32'(ac),  32'h0);
    check({tag, "_ecount"},  32'(ec),  32'h0);
  endtask

  task automatic run_table(input string tag);
    for (int i = 0; i < tbl.size(); i++) begin
      drive(tbl[i].word, tbl[i].k, tbl[i].req != 0);
      check($sformatf("%s_r%0d_aligned", tag, i), 32'(bus_a.link_aligned),       32'(tbl[i].al));
      check($sformatf("%s_r%0d_offset", tag, i),  32'(bus_a.offset_out),         32'(tbl[i].off));
      check($sformatf("%s_r%0d_acount", tag, i),  32'(bus_a.link_aligned_count), 32'(tbl[i].ac));
      check($sformatf("%s_r%0d_ecount", tag, i),  32'(bus_a.link_error_count),   32'(tbl[i].ec));
      if (tbl[i].cd != 0)
        check($sformatf("%s_r%0d_data", tag, i), bus_a.data_out, tbl[i].d);
    end
    tbl.delete();
  endtask

  initial begin
    logic [31:0] w;
    n_vec   = 0;
    n_err   = 0;
    rstb_a  = 1'b0;
    rstb_b  = 1'b0;
    raw_drv = 32'h0;
    pat_drv = IDLE;
    req_drv = 1'b0;
    a_prev  = 32'h0;

    repeat (3) @(posedge clk40);
    #1;
    check_zero("reset_a", bus_a.data_out, bus_a.link_aligned, bus_a.offset_out,
               bus_a.link_aligned_count, bus_a.link_error_count);
    rstb_a = 1'b1;

    // Lock at offset 7: first match on edge 2, eighth match (lock) on edge 9.
    tbl.push_back(mk(IDLE, 7, 0, 0, 0, 0, 0, 0, ZERO));
    tbl.push_back(mk(IDLE, 7, 0, 0, 7, 0, 0, 1, 32'h01599999));
    for (int i = 3; i <= 8; i++) tbl.push_back(mk(IDLE, 7, 0, 0, 7, 0, 0, 1, IDLE));
    tbl.push_back(mk(IDLE, 7, 0, 1, 7, 1, 0, 1, IDLE));
    tbl.push_back(mk(IDLE, 7, 0, 1, 7, 1, 0, 1, IDLE));
    run_table("lock");

    // Payload pass-through through the scoreboard.
    sb.push_back(IDLE);
    for (int i = 0; i < 80; i++) begin
      w = (i < 64) ? 32'h76543210 : 32'h10000001 + 32'(i - 64);
      sb.push_back(w);
      drive(w, 7, 1'b0);
      check($sformatf("payload_%0d_data", i), bus_a.data_out, sb.pop_front());
      check($sformatf("payload_%0d_aligned", i), 32'(bus_a.link_aligned), 32'h1);
    end
    sb.push_back(IDLE);
    drive(IDLE, 7, 1'b0);
    check("payload_last_data", bus_a.data_out, sb.pop_front());
    check("payload_ecount", 32'(bus_a.link_error_count), 32'h0);
    sb.delete();

    // Slip recovery: stream moves from offset 7 to 8 across a zero word.
    tbl.push_back(mk(IDLE, 7, 0, 1, 7, 1, 0, 1, IDLE));
    tbl.push_back(mk(ZERO, 7, 0, 1, 7, 1, 0, 1, IDLE));
    tbl.push_back(mk(IDLE, 8, 0, 1, 7, 1, 0, 1, ZERO));
    for (int e = 1; e <= 4; e++) tbl.push_back(mk(IDLE, 8, 0, (e < 4) ? 1 : 0, 7, 1, e, 0, ZERO));
    tbl.push_back(mk(IDLE, 8, 0, 0, 8, 1, 4, 0, ZERO));
    for (int i = 0; i < 6; i++) tbl.push_back(mk(IDLE, 8, 0, 0, 8, 1, 4, 1, IDLE));
    tbl.push_back(mk(IDLE, 8, 0, 1, 8, 2, 4, 1, IDLE));
    run_table("slip");

    // Reset request after 3 slips, then a broken confirmation and a clean relock.
    tbl.push_back(mk(ZERO, 8, 0, 1, 8, 2, 4, 1, IDLE));
    tbl.push_back(mk(IDLE, 9, 0, 1, 8, 2, 4, 1, ZERO));
    for (int e = 5; e <= 7; e++) tbl.push_back(mk(IDLE, 9, 0, 1, 8, 2, e, 0, ZERO));
    tbl.push_back(mk(IDLE, 9, 1, 0, 8, 2, 0, 0, ZERO));
    tbl.push_back(mk(IDLE, 9, 0, 0, 9, 2, 0, 0, ZERO));
    tbl.push_back(mk(IDLE, 9, 0, 0, 9, 2, 0, 1, IDLE));
    tbl.push_back(mk(BAD,  9, 0, 0, 9, 2, 0, 1, IDLE));
    tbl.push_back(mk(IDLE, 9, 0, 0, 9, 2, 0, 1, BAD));
    for (int i = 0; i < 7; i++) tbl.push_back(mk(IDLE, 9, 0, 0, 9, 2, 0, 1, IDLE));
    tbl.push_back(mk(IDLE, 9, 0, 1, 9, 3, 0, 1, IDLE));
    run_table("rstreq");

    // Instance B locks on the same stream, then both see 300 isolated slips.
    check_zero("reset_b", bus_b.data_out, bus_b.link_aligned, bus_b.offset_out,
               bus_b.link_aligned_count, bus_b.link_error_count);
    rstb_b = 1'b1;
    for (int i = 0; i < 10; i++) drive(IDLE, 9, 1'b0);
    check("lock_b_aligned", 32'(bus_b.link_aligned),       32'h1);
    check("lock_b_offset",  32'(bus_b.offset_out),         32'd9);
    check("lock_b_acount",  32'(bus_b.link_aligned_count), 32'h1);
    check("lock_b_data",    bus_b.data_out,                IDLE);

    drive(ZERO, 9, 1'b0);
    for (int i = 1; i <= 300; i++) begin
      drive(IDLE, 10, 1'b0);
      drive(ZERO, 10, 1'b0);
      if (i == 200 || i == 255 || i == 300) begin
        check($sformatf("sat_a_%0d_ecount", i), 32'(bus_a.link_error_count), 32'((i > 255) ? 255 : i));
        check($sformatf("sat_b_%0d_ecount", i), 32'(bus_b.link_error_count), 32'((i > 255) ? 255 : i));
      end
    end
    check("sat_a_aligned", 32'(bus_a.link_aligned), 32'h1);
    check("sat_b_aligned", 32'(bus_b.link_aligned), 32'h1);
    check("sat_b_offset",  32'(bus_b.offset_out),   32'd9);

    // Asynchronous reset mid-cycle while aligned: outputs clear before the next edge.
    #3;
    rstb_a = 1'b0;
    rstb_b = 1'b0;
    #1;
    check_zero("areset_a", bus_a.data_out, bus_a.link_aligned, bus_a.offset_out,
               bus_a.link_aligned_count, bus_a.link_error_count);
    check_zero("areset_b", bus_b.data_out, bus_b.link_aligned, bus_b.offset_out,
               bus_b.link_aligned_count, bus_b.link_error_count);
    @(posedge clk40);
    #1;
    check("areset_hold_aligned", 32'(bus_a.link_aligned), 32'h0);
    rstb_a = 1'b1;
    rstb_b = 1'b1;

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
